// File: rtl/dmem_responder_if.sv
// Data-memory port bundle: tagged load request/response channels plus a store channel with completion.
// The master drives requests; the slave (dmem_responder) answers.
interface dmem_if #(
    parameter int unsigned LDTAG_W = 4
);
    logic               ld_valid;
    logic               ld_ready;
    logic [31:0]        ld_addr;
    logic [2:0]         ld_size;
    logic [LDTAG_W-1:0] ld_tag;
    logic               ld_resp_valid;
    logic               ld_resp_ready;
    logic [LDTAG_W-1:0] ld_resp_tag;
    logic [63:0]        ld_resp_data;
    logic               ld_resp_err;
    logic               st_valid;
    logic               st_ready;
    logic [31:0]        st_addr;
    logic [2:0]         st_size;
    logic [63:0]        st_wdata;
    logic [7:0]         st_wstrb;
    logic               st_resp_valid;
    logic               st_resp_ready;

    modport master (
        output ld_valid, ld_addr, ld_size, ld_tag, ld_resp_ready,
        output st_valid, st_addr, st_size, st_wdata, st_wstrb, st_resp_ready,
        input  ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err,
        input  st_ready, st_resp_valid
    );

    modport slave (
        input  ld_valid, ld_addr, ld_size, ld_tag, ld_resp_ready,
        input  st_valid, st_addr, st_size, st_wdata, st_wstrb, st_resp_ready,
        output ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err,
        output st_ready, st_resp_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Doubleword data memory answering pipelined, in-order tagged loads and single-outstanding byte-strobed stores.
// Loads flow through a fixed-latency pipeline into a response FIFO; stores run a two-state completion FSM.
module dmem_responder #(
    parameter int unsigned LDTAG_W   = 4,
    parameter int unsigned MEM_DW    = 1024,
    parameter int unsigned LD_LAT    = 2,
    parameter int unsigned LDQ_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(MEM_DW);
    localparam int unsigned CNT_W = $clog2(LDQ_DEPTH + 1);
    localparam int unsigned PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;

    typedef struct packed {
        logic [LDTAG_W-1:0] tag;
        logic [63:0]        data;
        logic               err;
    } ld_ent_t;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } st_state_t;

    // Storage is intentionally left unreset
    logic [63:0] mem [MEM_DW];

    logic             ld_fire;
    logic             ld_misalign;
    logic             ld_oor;
    logic             ld_err;
    logic [IDX_W-1:0] ld_idx;
    ld_ent_t          ld_in;

    ld_ent_t          push_ent;
    logic             push_v;

    ld_ent_t          fifo [LDQ_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] ld_cnt;
    logic             pop;
    ld_ent_t          head;

    st_state_t        st_state;
    st_state_t        st_next;
    logic             st_we;
    logic             st_oor;
    logic [IDX_W-1:0] st_idx;
    logic             unused_st;

    // Load request decode: size/alignment/range error and same-cycle array read
    always_comb begin
        ld_misalign = 1'b0;
        case (bus.ld_size)
            3'd0:    ld_misalign = 1'b0;
            3'd1:    ld_misalign = bus.ld_addr[0];
            3'd2:    ld_misalign = |bus.ld_addr[1:0];
            3'd3:    ld_misalign = |bus.ld_addr[2:0];
            default: ld_misalign = 1'b1;
        endcase
    end

    assign ld_oor   = {3'b000, bus.ld_addr[31:3]} >= 32'(MEM_DW);
    assign ld_err   = ld_misalign || ld_oor;
    assign ld_idx   = bus.ld_addr[IDX_W+2:3];
    assign ld_fire  = bus.ld_valid && bus.ld_ready;
    assign ld_in.tag  = bus.ld_tag;
    assign ld_in.data = ld_err ? 64'd0 : mem[ld_idx];
    assign ld_in.err  = ld_err;

    assign bus.ld_ready = !rst && (ld_cnt < CNT_W'(LDQ_DEPTH));

    // LD_LAT-1 register stages; the final stage edge is the FIFO write itself
    generate
        if (LD_LAT == 1) begin : g_nopipe
            assign push_v   = ld_fire;
            assign push_ent = ld_in;
        end else begin : g_pipe
            ld_ent_t           stg [LD_LAT-1];
            logic [LD_LAT-2:0] stg_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_v <= '0;
                    for (int i = 0; i < int'(LD_LAT) - 1; i++) begin
                        stg[i] <= '0;
                    end
                end else begin
                    stg_v[0] <= ld_fire;
                    stg[0]   <= ld_in;
                    for (int i = 1; i < int'(LD_LAT) - 1; i++) begin
                        stg_v[i] <= stg_v[i-1];
                        stg[i]   <= stg[i-1];
                    end
                end
            end

            assign push_v   = stg_v[LD_LAT-2];
            assign push_ent = stg[LD_LAT-2];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LDQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.ld_resp_valid = (fcnt != '0);
    assign pop               = bus.ld_resp_valid && bus.ld_resp_ready;

    // Response FIFO control; ld_cnt gating guarantees it never overflows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (push_v) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push_v, pop})
                2'b10:   fcnt <= fcnt + CNT_W'(1);
                2'b01:   fcnt <= fcnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_v) begin
            fifo[wptr] <= push_ent;
        end
    end

    // Head is held until popped, so stalled responses stay stable; idle outputs read as zero
    assign head              = bus.ld_resp_valid ? fifo[rptr] : '0;
    assign bus.ld_resp_tag   = head.tag;
    assign bus.ld_resp_data  = head.data;
    assign bus.ld_resp_err   = head.err;

    // Outstanding loads: pipeline plus FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
        end else begin
            case ({ld_fire, pop})
                2'b10:   ld_cnt <= ld_cnt + CNT_W'(1);
                2'b01:   ld_cnt <= ld_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign st_oor = {3'b000, bus.st_addr[31:3]} >= 32'(MEM_DW);
    assign st_idx = bus.st_addr[IDX_W+2:3];

    // Stores ignore size and byte offset: the strobes alone select bytes
    assign unused_st = ^{bus.st_size, bus.st_addr[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_state <= ST_IDLE;
        end else begin
            st_state <= st_next;
        end
    end

    always_comb begin
        st_next           = st_state;
        bus.st_ready      = 1'b0;
        bus.st_resp_valid = 1'b0;
        st_we             = 1'b0;
        case (st_state)
            ST_IDLE: begin
                bus.st_ready = !rst;
                if (bus.st_valid && !rst) begin
                    st_we   = !st_oor;
                    st_next = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.st_resp_valid = 1'b1;
                if (bus.st_resp_ready) begin
                    st_next = ST_IDLE;
                end
            end
            default: st_next = ST_IDLE;
        endcase
    end

    // Write lands on the acceptance edge; a same-cycle load already sampled the old word
    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.st_wstrb[b]) begin
                    mem[st_idx][8*b +: 8] <= bus.st_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single loads plus hand sequences for
// backpressure, store/load hazard, out-of-range store and mid-operation reset.
module tb_dmem_responder;
    localparam int unsigned LDTAG_W   = 4;
    localparam int unsigned MEM_DW    = 1024;
    localparam int unsigned LD_LAT    = 2;
    localparam int unsigned LDQ_DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  tag;
        logic [63:0] data;
        logic        err;
    } ld_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_if #(.LDTAG_W(LDTAG_W)) bus ();

    dmem_responder #(
        .LDTAG_W  (LDTAG_W),
        .MEM_DW   (MEM_DW),
        .LD_LAT   (LD_LAT),
        .LDQ_DEPTH(LDQ_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ld_valid      = 1'b0;
        bus.ld_addr       = '0;
        bus.ld_size       = '0;
        bus.ld_tag        = '0;
        bus.ld_resp_ready = 1'b0;
        bus.st_valid      = 1'b0;
        bus.st_addr       = '0;
        bus.st_size       = '0;
        bus.st_wdata      = '0;
        bus.st_wstrb      = '0;
        bus.st_resp_ready = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        @(negedge clk);
        chk1("st_ready_idle", bus.st_ready, 1'b1);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_size  = 3'd3;
        bus.st_wdata = wd;
        bus.st_wstrb = ws;
        @(negedge clk);
        bus.st_valid = 1'b0;
        chk1("st_resp_valid", bus.st_resp_valid, 1'b1);
        chk1("st_ready_in_resp", bus.st_ready, 1'b0);
        bus.st_resp_ready = 1'b1;
        @(negedge clk);
        bus.st_resp_ready = 1'b0;
        chk1("st_ready_after_resp", bus.st_ready, 1'b1);
        chk1("st_resp_valid_clear", bus.st_resp_valid, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] tag,
                           output logic [63:0] data, output logic [3:0] rtag, output logic err,
                           output int lat);
        @(negedge clk);
        chk1("ld_ready", bus.ld_ready, 1'b1);
        bus.ld_valid      = 1'b1;
        bus.ld_addr       = addr;
        bus.ld_size       = size;
        bus.ld_tag        = tag;
        bus.ld_resp_ready = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        lat = 1;
        while (!bus.ld_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.ld_resp_valid) begin
            checks++;
            failures++;
            $display("FAIL ld_timeout: no response for addr 0x%0h after %0d cycles", addr, lat);
        end
        data = bus.ld_resp_data;
        rtag = bus.ld_resp_tag;
        err  = bus.ld_resp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ld_vec_t     vecs [12];
        ld_vec_t     bp   [4];
        logic [63:0] d;
        logic [3:0]  t;
        logic        e;
        int          lat;

        vecs[0]  = '{32'h0000_0010, 3'd3, 4'd3,  64'h1122334455667788, 1'b0};
        vecs[1]  = '{32'h0000_0012, 3'd1, 4'd5,  64'h1122334455667788, 1'b0};
        vecs[2]  = '{32'h0000_0014, 3'd2, 4'd6,  64'h1122334455667788, 1'b0};
        vecs[3]  = '{32'h0000_0017, 3'd0, 4'd7,  64'h1122334455667788, 1'b0};
        vecs[4]  = '{32'h0000_1FF8, 3'd3, 4'd8,  64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[5]  = '{32'h0000_1FFC, 3'd2, 4'd11, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[6]  = '{32'h0000_0002, 3'd2, 4'd1,  64'h0, 1'b1};
        vecs[7]  = '{32'h0000_0000, 3'd4, 4'd2,  64'h0, 1'b1};
        vecs[8]  = '{32'h0000_2000, 3'd3, 4'd4,  64'h0, 1'b1};
        vecs[9]  = '{32'h0000_0014, 3'd3, 4'd9,  64'h0, 1'b1};
        vecs[10] = '{32'h0000_0013, 3'd1, 4'd10, 64'h0, 1'b1};
        vecs[11] = '{32'hFFFF_FFF8, 3'd3, 4'd12, 64'h0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_ld_ready", bus.ld_ready, 1'b0);
        chk1("rst_st_ready", bus.st_ready, 1'b0);
        chk1("rst_ld_resp_valid", bus.ld_resp_valid, 1'b0);
        chk1("rst_st_resp_valid", bus.st_resp_valid, 1'b0);
        chk64("rst_resp_tag", 64'(bus.ld_resp_tag), 64'h0);
        chk64("rst_resp_data", bus.ld_resp_data, 64'h0);
        chk1("rst_resp_err", bus.ld_resp_err, 1'b0);
        rst = 1'b0;
        #1;
        chk1("post_rst_ld_ready", bus.ld_ready, 1'b1);
        chk1("post_rst_st_ready", bus.st_ready, 1'b1);

        do_store(32'h10, 64'h1122334455667788, 8'hFF);
        do_store(32'h1FF8, 64'hDEADBEEFCAFEF00D, 8'hFF);

        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].addr, vecs[i].size, vecs[i].tag, d, t, e, lat);
            chk64($sformatf("vec%0d_data", i), d, vecs[i].data);
            chk64($sformatf("vec%0d_tag", i), 64'(t), 64'(vecs[i].tag));
            chk1($sformatf("vec%0d_err", i), e, vecs[i].err);
            chk64($sformatf("vec%0d_lat", i), 64'(lat), 64'(LD_LAT));
        end

        // Partial strobes
        do_store(32'h10, 64'h0, 8'hFF);
        do_store(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        do_load(32'h10, 3'd3, 4'd1, d, t, e, lat);
        chk64("strb_lo_data", d, 64'h00000000FFFFFFFF);
        do_store(32'h10, 64'h1122334455667788, 8'h80);
        do_load(32'h10, 3'd3, 4'd2, d, t, e, lat);
        chk64("strb_top_data", d, 64'h11000000FFFFFFFF);

        // Same-cycle store and load to word 0: load sees the old value
        do_store(32'h0, 64'hA, 8'hFF);
        @(negedge clk);
        bus.st_valid      = 1'b1;
        bus.st_addr       = 32'h0;
        bus.st_wdata      = 64'hB;
        bus.st_wstrb      = 8'hFF;
        bus.ld_valid      = 1'b1;
        bus.ld_addr       = 32'h0;
        bus.ld_size       = 3'd3;
        bus.ld_tag        = 4'd14;
        bus.ld_resp_ready = 1'b1;
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        chk1("haz_st_resp_valid", bus.st_resp_valid, 1'b1);
        chk1("haz_ld_not_yet", bus.ld_resp_valid, 1'b0);
        bus.st_resp_ready = 1'b1;
        @(negedge clk);
        bus.st_resp_ready = 1'b0;
        chk1("haz_st_ready_back", bus.st_ready, 1'b1);
        chk1("haz_ld_valid", bus.ld_resp_valid, 1'b1);
        chk64("haz_ld_data_old", bus.ld_resp_data, 64'hA);
        chk64("haz_ld_tag", 64'(bus.ld_resp_tag), 64'd14);
        do_load(32'h0, 3'd3, 4'd15, d, t, e, lat);
        chk64("haz_ld_data_new", d, 64'hB);

        // Out-of-range store completes but must not alias onto word 0
        do_store(32'h2000, 64'h5555, 8'hFF);
        do_load(32'h0, 3'd3, 4'd0, d, t, e, lat);
        chk64("oor_store_no_write", d, 64'hB);

        // Backpressure: fill four outstanding, then drain in order
        bp[0] = '{32'h0000_0010, 3'd3, 4'd0, 64'h11000000FFFFFFFF, 1'b0};
        bp[1] = '{32'h0000_1FF8, 3'd3, 4'd1, 64'hDEADBEEFCAFEF00D, 1'b0};
        bp[2] = '{32'h0000_0000, 3'd3, 4'd2, 64'hB, 1'b0};
        bp[3] = '{32'h0000_0002, 3'd2, 4'd3, 64'h0, 1'b1};
        @(negedge clk);
        bus.ld_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("bp_ready%0d", i), bus.ld_ready, 1'b1);
            bus.ld_valid = 1'b1;
            bus.ld_addr  = bp[i].addr;
            bus.ld_size  = bp[i].size;
            bus.ld_tag   = bp[i].tag;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        chk1("bp_full_ready", bus.ld_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk1("bp_stall_valid", bus.ld_resp_valid, 1'b1);
        chk64("bp_stall_tag", 64'(bus.ld_resp_tag), 64'd0);
        chk64("bp_stall_data", bus.ld_resp_data, bp[0].data);
        @(negedge clk);
        chk64("bp_stable_tag", 64'(bus.ld_resp_tag), 64'd0);
        chk64("bp_stable_data", bus.ld_resp_data, bp[0].data);
        chk1("bp_still_full", bus.ld_ready, 1'b0);
        bus.ld_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("bp_drain_valid%0d", i), bus.ld_resp_valid, 1'b1);
            chk64($sformatf("bp_drain_tag%0d", i), 64'(bus.ld_resp_tag), 64'(bp[i].tag));
            chk64($sformatf("bp_drain_data%0d", i), bus.ld_resp_data, bp[i].data);
            chk1($sformatf("bp_drain_err%0d", i), bus.ld_resp_err, bp[i].err);
            @(negedge clk);
        end
        chk1("bp_drained", bus.ld_resp_valid, 1'b0);
        chk1("bp_ready_again", bus.ld_ready, 1'b1);

        // Reset with loads in flight and a store parked in RESP
        bus.ld_resp_ready = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        bus.ld_size  = 3'd3;
        bus.ld_tag   = 4'd1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h18;
        bus.st_wdata = 64'h0123456789ABCDEF;
        bus.st_wstrb = 8'hFF;
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.ld_tag   = 4'd2;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk1("mid_st_in_resp", bus.st_resp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_ld_ready", bus.ld_ready, 1'b0);
        chk1("mid_rst_st_ready", bus.st_ready, 1'b0);
        chk1("mid_rst_ld_resp_valid", bus.ld_resp_valid, 1'b0);
        chk1("mid_rst_st_resp_valid", bus.st_resp_valid, 1'b0);
        chk64("mid_rst_resp_data", bus.ld_resp_data, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("mid_post_ld_ready", bus.ld_ready, 1'b1);
        chk1("mid_post_st_ready", bus.st_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1($sformatf("mid_no_ld_resp%0d", i), bus.ld_resp_valid, 1'b0);
            chk1($sformatf("mid_no_st_resp%0d", i), bus.st_resp_valid, 1'b0);
        end
        // Outstanding count must be zero: four fresh loads fit
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("mid_cnt_ready%0d", i), bus.ld_ready, 1'b1);
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 32'h18;
            bus.ld_size  = 3'd3;
            bus.ld_tag   = 4'(i);
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        chk1("mid_cnt_full", bus.ld_ready, 1'b0);
        bus.ld_resp_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk1("mid_cnt_drained", bus.ld_resp_valid, 1'b0);
        do_load(32'h18, 3'd3, 4'd5, d, t, e, lat);
        chk64("mid_store_kept", d, 64'h0123456789ABCDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
